// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the IF/ID, ID/EX and EX/MEM pipeline latches.
// Resolves per-stage hazard requests, redirects the PC on mispredict and counts fetch stalls.
module pipe_hazard_ctrl #(
  parameter int unsigned MULDIV_LAT     = 4,
  parameter int unsigned REDIRECT_FLUSH = 2,
  parameter int unsigned CNT_W          = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ICACHE_MISS,
  input  logic        LOAD_USE,
  input  logic        MULDIV_START,
  input  logic        MISPREDICT,
  input  logic [31:0] MISPREDICT_TARGET,
  input  logic        DCACHE_MISS,
  output logic        STALL_IF,
  output logic        STALL_IFID,
  output logic        FLUSH_IFID,
  output logic        STALL_IDEX,
  output logic        FLUSH_IDEX,
  output logic        STALL_EXMEM,
  output logic        FLUSH_EXMEM,
  output logic        PC_REDIRECT,
  output logic [31:0] PC_TARGET,
  output logic [1:0]  STATE_OUT,
  output logic [31:0] STALL_COUNT
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DMISS  = 2'd1,
    S_MULDIV = 2'd2,
    S_REDIR  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MULDIV_LOAD = CNT_W'(MULDIV_LAT - 1);
  localparam logic [CNT_W-1:0] REDIR_LOAD  = CNT_W'(REDIRECT_FLUSH - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic [31:0]      r_stall_cnt;

  logic w_stall_if, w_stall_ifid, w_flush_ifid, w_stall_idex;
  logic w_flush_idex, w_stall_exmem, w_flush_exmem, w_redirect;

  // DMISS shares the RUN evaluation: with the miss still present it picks the
  // all-stall branch and stays, otherwise it exits in the same cycle.
  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_cnt;
    w_stall_if    = 1'b0;
    w_stall_ifid  = 1'b0;
    w_flush_ifid  = 1'b0;
    w_stall_idex  = 1'b0;
    w_flush_idex  = 1'b0;
    w_stall_exmem = 1'b0;
    w_flush_exmem = 1'b0;
    w_redirect    = 1'b0;
    unique case (r_state)
      S_RUN, S_DMISS: begin
        if (DCACHE_MISS) begin
          w_stall_if    = 1'b1;
          w_stall_ifid  = 1'b1;
          w_stall_idex  = 1'b1;
          w_stall_exmem = 1'b1;
          w_next_state  = S_DMISS;
        end else if (MISPREDICT) begin
          w_redirect   = 1'b1;
          w_flush_ifid = 1'b1;
          w_flush_idex = 1'b1;
          w_next_cnt   = REDIR_LOAD;
          w_next_state = (REDIRECT_FLUSH > 1) ? S_REDIR : S_RUN;
        end else if (MULDIV_START) begin
          w_stall_if    = 1'b1;
          w_stall_ifid  = 1'b1;
          w_stall_idex  = 1'b1;
          w_flush_exmem = 1'b1;
          w_next_cnt    = MULDIV_LOAD;
          w_next_state  = (MULDIV_LAT > 1) ? S_MULDIV : S_RUN;
        end else if (LOAD_USE) begin
          w_stall_if   = 1'b1;
          w_stall_ifid = 1'b1;
          w_flush_idex = 1'b1;
          w_next_state = S_RUN;
        end else begin
          w_stall_if   = ICACHE_MISS;
          w_flush_ifid = ICACHE_MISS;
          w_next_state = S_RUN;
        end
      end
      S_MULDIV: begin
        w_stall_if   = 1'b1;
        w_stall_ifid = 1'b1;
        w_stall_idex = 1'b1;
        if (DCACHE_MISS) w_stall_exmem = 1'b1;
        else             w_flush_exmem = 1'b1;
        if (r_cnt != '0) w_next_cnt = r_cnt - 1'b1;
        if (r_cnt <= CNT_W'(1)) w_next_state = DCACHE_MISS ? S_DMISS : S_RUN;
      end
      S_REDIR: begin
        w_flush_ifid = 1'b1;
        if (DCACHE_MISS) begin
          w_stall_if    = 1'b1;
          w_stall_ifid  = 1'b1;
          w_stall_idex  = 1'b1;
          w_stall_exmem = 1'b1;
        end else begin
          w_stall_if = ICACHE_MISS;
          if (r_cnt != '0) w_next_cnt = r_cnt - 1'b1;
          if (r_cnt <= CNT_W'(1)) w_next_state = S_RUN;
        end
      end
      default: w_next_state = S_RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= S_RUN;
      r_cnt       <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_stall_if && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign STALL_IF    = RESET & w_stall_if;
  assign STALL_IFID  = RESET & w_stall_ifid;
  assign STALL_IDEX  = RESET & w_stall_idex;
  assign STALL_EXMEM = RESET & w_stall_exmem;
  assign FLUSH_IFID  = ~RESET | w_flush_ifid;
  assign FLUSH_IDEX  = ~RESET | w_flush_idex;
  assign FLUSH_EXMEM = ~RESET | w_flush_exmem;
  assign PC_REDIRECT = RESET & w_redirect;
  assign PC_TARGET   = PC_REDIRECT ? MISPREDICT_TARGET : '0;
  assign STATE_OUT   = r_state;
  assign STALL_COUNT = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a per-cycle vector table plus hand-written
// sequences for mid-sequence reset and stall-counter saturation.
module tb_pipe_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        ICACHE_MISS = 1'b0, LOAD_USE = 1'b0, MULDIV_START = 1'b0;
  logic        MISPREDICT = 1'b0, DCACHE_MISS = 1'b0;
  logic [31:0] MISPREDICT_TARGET = '0;
  logic        STALL_IF, STALL_IFID, FLUSH_IFID, STALL_IDEX, FLUSH_IDEX;
  logic        STALL_EXMEM, FLUSH_EXMEM, PC_REDIRECT;
  logic [31:0] PC_TARGET, STALL_COUNT;
  logic [1:0]  STATE_OUT;

  int unsigned total = 0;
  int unsigned bad   = 0;

  pipe_hazard_ctrl #(.MULDIV_LAT(4), .REDIRECT_FLUSH(2), .CNT_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .ICACHE_MISS(ICACHE_MISS), .LOAD_USE(LOAD_USE),
    .MULDIV_START(MULDIV_START), .MISPREDICT(MISPREDICT),
    .MISPREDICT_TARGET(MISPREDICT_TARGET), .DCACHE_MISS(DCACHE_MISS),
    .STALL_IF(STALL_IF), .STALL_IFID(STALL_IFID), .FLUSH_IFID(FLUSH_IFID),
    .STALL_IDEX(STALL_IDEX), .FLUSH_IDEX(FLUSH_IDEX), .STALL_EXMEM(STALL_EXMEM),
    .FLUSH_EXMEM(FLUSH_EXMEM), .PC_REDIRECT(PC_REDIRECT), .PC_TARGET(PC_TARGET),
    .STATE_OUT(STATE_OUT), .STALL_COUNT(STALL_COUNT)
  );

  always #5 CLK = ~CLK;

  // ctl bits: {rst_n, icache, load_use, muldiv, mispredict, dcache}
  // exp bits: {SIF, SIFID, FIFID, SIDEX, FIDEX, SEXMEM, FEXMEM, REDIRECT}
  typedef struct {
    logic [5:0]  ctl;
    logic [31:0] tgt_in;
    logic [7:0]  exp;
    logic [31:0] exp_tgt;
    logic [1:0]  exp_state;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] out_bits();
    return {STALL_IF, STALL_IFID, FLUSH_IFID, STALL_IDEX, FLUSH_IDEX,
            STALL_EXMEM, FLUSH_EXMEM, PC_REDIRECT};
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic drive(input logic [5:0] ctl, input logic [31:0] tgt);
    RESET             = ctl[5];
    ICACHE_MISS       = ctl[4];
    LOAD_USE          = ctl[3];
    MULDIV_START      = ctl[2];
    MISPREDICT        = ctl[1];
    DCACHE_MISS       = ctl[0];
    MISPREDICT_TARGET = tgt;
  endtask

  task automatic add(input logic [5:0] ctl, input logic [31:0] tin, input logic [7:0] e,
                     input logic [31:0] et, input logic [1:0] es, input logic [31:0] ec);
    vec_t v;
    v.ctl = ctl; v.tgt_in = tin; v.exp = e; v.exp_tgt = et; v.exp_state = es; v.exp_cnt = ec;
    vecs.push_back(v);
  endtask

  localparam logic [31:0] T = 32'h0040_0100;
  localparam logic [31:0] U = 32'hDEAD_BEE0;

  initial begin
    //        rIlMpd       tgt in  exp     exp_tgt st  cnt
    add(6'b000000, '0, 8'h2A, '0, 2'd0, 0);  // reset
    add(6'b100000, '0, 8'h00, '0, 2'd0, 0);
    add(6'b100010, T,  8'h29, T,  2'd0, 0);  // mispredict
    add(6'b100000, T,  8'h20, '0, 2'd3, 0);
    add(6'b100000, '0, 8'h00, '0, 2'd0, 0);
    add(6'b100100, '0, 8'hD2, '0, 2'd0, 0);  // muldiv, 4 busy cycles
    add(6'b100000, '0, 8'hD2, '0, 2'd2, 1);
    add(6'b100000, '0, 8'hD2, '0, 2'd2, 2);
    add(6'b100000, '0, 8'hD2, '0, 2'd2, 3);
    add(6'b100000, '0, 8'h00, '0, 2'd0, 4);
    add(6'b100011, T,  8'hD4, '0, 2'd0, 4);  // dmiss drops mispredict
    add(6'b100001, '0, 8'hD4, '0, 2'd1, 5);
    add(6'b100001, '0, 8'hD4, '0, 2'd1, 6);
    add(6'b100010, T,  8'h29, T,  2'd1, 7);  // zero-cycle exit from DMISS
    add(6'b100000, '0, 8'h20, '0, 2'd3, 7);
    add(6'b100000, '0, 8'h00, '0, 2'd0, 7);
    add(6'b111000, '0, 8'hC8, '0, 2'd0, 7);  // load-use beats icache
    add(6'b110000, '0, 8'hA0, '0, 2'd0, 8);
    add(6'b101000, '0, 8'hC8, '0, 2'd0, 9);
    add(6'b100010, U,  8'h29, U,  2'd0, 10);
    add(6'b100001, '0, 8'hF4, '0, 2'd3, 10); // dcache in REDIR: no count-down
    add(6'b110000, '0, 8'hA0, '0, 2'd3, 11);
    add(6'b100000, '0, 8'h00, '0, 2'd0, 12);
    add(6'b100100, '0, 8'hD2, '0, 2'd0, 12);
    add(6'b100001, '0, 8'hD4, '0, 2'd2, 13);
    add(6'b100010, U,  8'hD2, '0, 2'd2, 14); // mispredict ignored in MULDIV
    add(6'b100001, '0, 8'hD4, '0, 2'd2, 15);
    add(6'b100000, '0, 8'h00, '0, 2'd1, 16);
    add(6'b100000, '0, 8'h00, '0, 2'd0, 16);
    add(6'b101110, T,  8'h29, T,  2'd0, 16); // mispredict beats muldiv/load-use
    add(6'b100100, '0, 8'h20, '0, 2'd3, 16);
    add(6'b100000, '0, 8'h00, '0, 2'd0, 16);

    drive(6'b000000, '0);
    repeat (2) @(posedge CLK);
    foreach (vecs[i]) begin
      #1 drive(vecs[i].ctl, vecs[i].tgt_in);
      #3;
      check32($sformatf("v%0d.outs", i), {24'd0, out_bits()}, {24'd0, vecs[i].exp});
      check32($sformatf("v%0d.target", i), PC_TARGET, vecs[i].exp_tgt);
      check32($sformatf("v%0d.state", i), {30'd0, STATE_OUT}, {30'd0, vecs[i].exp_state});
      check32($sformatf("v%0d.count", i), STALL_COUNT, vecs[i].exp_cnt);
      @(posedge CLK);
    end

    // Reset in the second MULDIV cycle
    #1 drive(6'b100100, '0);
    @(posedge CLK);
    #1 drive(6'b100000, '0);
    @(posedge CLK);
    #1 drive(6'b000000, '0);
    #3;
    check32("rst_mid.outs", {24'd0, out_bits()}, 32'h2A);
    check32("rst_mid.count", STALL_COUNT, 32'd0);
    @(posedge CLK);
    #1 drive(6'b100000, '0);
    @(posedge CLK);
    #4;
    check32("rst_rel.outs", {24'd0, out_bits()}, 32'h00);
    check32("rst_rel.state", {30'd0, STATE_OUT}, 32'd0);
    check32("rst_rel.count", STALL_COUNT, 32'd0);

    // Saturation of the stall counter
    @(posedge CLK);
    #1 dut.r_stall_cnt = 32'hFFFF_FFFE;
    drive(6'b110000, '0);
    @(posedge CLK);
    #4 check32("sat.step", STALL_COUNT, 32'hFFFF_FFFF);
    @(posedge CLK);
    #4 check32("sat.hold1", STALL_COUNT, 32'hFFFF_FFFF);
    @(posedge CLK);
    #4 check32("sat.hold2", STALL_COUNT, 32'hFFFF_FFFF);
    #1 drive(6'b100000, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
